reg_n_universal: RTL and testbench

Parametrised successor to the team's fixed 4-bit register. It is a W-bit universal register: hold, parallel load, shift, rotate, increment and decrement, with serial in/out, a zero flag and a sticky wrap flag. It serves as the general-purpose storage/counter element for datapath exercises in this codebase, and is intended to replace ad-hoc 4-bit registers and counters.

---
 rtl/reg_n_universal.sv | 92 +++++++++
 tb/tb_reg_n_universal.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/reg_n_universal.sv
// W-bit universal register: hold, load, shift, rotate, increment and decrement,
// with serial output, a zero flag and a sticky wrap flag.
module reg_n_universal #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Clr,
    input  logic         En,
    input  logic [2:0]   Mode,
    input  logic [W-1:0] I,
    input  logic         Sin,
    output logic [W-1:0] Q,
    output logic         Sout,
    output logic         Zero,
    output logic         Ovf
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    logic [W-1:0] q_nxt;
    logic         sout_nxt;
    logic         ovf_nxt;

    always_comb begin
        q_nxt    = Q;
        sout_nxt = Sout;
        ovf_nxt  = Ovf;
        case (mode_t'(Mode))
            MODE_HOLD: ;
            MODE_LOAD: begin
                q_nxt   = I;
                ovf_nxt = 1'b0;
            end
            MODE_SHL: begin
                q_nxt    = {Q[W-2:0], Sin};
                sout_nxt = Q[W-1];
            end
            MODE_SHR: begin
                q_nxt    = {Sin, Q[W-1:1]};
                sout_nxt = Q[0];
            end
            MODE_ROTL: begin
                q_nxt    = {Q[W-2:0], Q[W-1]};
                sout_nxt = Q[W-1];
            end
            MODE_ROTR: begin
                q_nxt    = {Q[0], Q[W-1:1]};
                sout_nxt = Q[0];
            end
            // Wrap detection uses the pre-update value; Ovf is sticky until load/Clr/Rst.
            MODE_INC: begin
                q_nxt   = Q + {{(W-1){1'b0}}, 1'b1};
                ovf_nxt = Ovf | (&Q);
            end
            MODE_DEC: begin
                q_nxt   = Q - {{(W-1){1'b0}}, 1'b1};
                ovf_nxt = Ovf | ~(|Q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Q    <= RST_VAL;
            Sout <= 1'b0;
            Ovf  <= 1'b0;
        end else if (Clr) begin
            Q    <= '0;
            Sout <= 1'b0;
            Ovf  <= 1'b0;
        end else if (En) begin
            Q    <= q_nxt;
            Sout <= sout_nxt;
            Ovf  <= ovf_nxt;
        end
    end

    assign Zero = (Q == '0);

endmodule

// File: tb/tb_reg_n_universal.sv
// Directed bench for reg_n_universal: a W=4 instance and a W=8, RST_VAL=A5 instance.
module tb_reg_n_universal;

    logic       Clk_s = 1'b0;
    always #5 Clk_s = ~Clk_s;

    logic       rst_a, clr_a, en_a, sin_a;
    logic [2:0] mode_a;
    logic [3:0] i_a, q_a;
    logic       sout_a, zero_a, ovf_a;

    logic       rst_b, clr_b, en_b, sin_b;
    logic [2:0] mode_b;
    logic [7:0] i_b, q_b;
    logic       sout_b, zero_b, ovf_b;

    int n_assert = 0;
    int n_fail   = 0;

    reg_n_universal #(.W(4), .RST_VAL(4'h0)) dut_a (
        .Clk(Clk_s), .Rst(rst_a), .Clr(clr_a), .En(en_a), .Mode(mode_a),
        .I(i_a), .Sin(sin_a), .Q(q_a), .Sout(sout_a), .Zero(zero_a), .Ovf(ovf_a)
    );

    reg_n_universal #(.W(8), .RST_VAL(8'hA5)) dut_b (
        .Clk(Clk_s), .Rst(rst_b), .Clr(clr_b), .En(en_b), .Mode(mode_b),
        .I(i_b), .Sin(sin_b), .Q(q_b), .Sout(sout_b), .Zero(zero_b), .Ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic rst, input logic clr, input logic en,
                          input logic [2:0] mode, input logic [3:0] i, input logic sin);
        rst_a = rst; clr_a = clr; en_a = en; mode_a = mode; i_a = i; sin_a = sin;
        @(posedge Clk_s);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic clr, input logic en,
                          input logic [2:0] mode, input logic [7:0] i, input logic sin);
        rst_b = rst; clr_b = clr; en_b = en; mode_b = mode; i_b = i; sin_b = sin;
        @(posedge Clk_s);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] q, input logic so,
                         input logic ov, input logic z);
        chk({tag, ".Q"},    {4'h0, q_a}, {4'h0, q});
        chk({tag, ".Sout"}, {7'h0, sout_a}, {7'h0, so});
        chk({tag, ".Ovf"},  {7'h0, ovf_a}, {7'h0, ov});
        chk({tag, ".Zero"}, {7'h0, zero_a}, {7'h0, z});
    endtask

    task automatic chk_b(input string tag, input logic [7:0] q, input logic so,
                         input logic ov, input logic z);
        chk({tag, ".Q"},    q_b, q);
        chk({tag, ".Sout"}, {7'h0, sout_b}, {7'h0, so});
        chk({tag, ".Ovf"},  {7'h0, ovf_b}, {7'h0, ov});
        chk({tag, ".Zero"}, {7'h0, zero_b}, {7'h0, z});
    endtask

    initial begin
        // Keep the W=8 instance in reset while the W=4 instance is exercised.
        rst_b = 1'b0; clr_b = 1'b0; en_b = 1'b0; mode_b = 3'b000; i_b = 8'h00; sin_b = 1'b0;

        // Reset beats a pending load; then load takes effect.
        step_a(1'b0, 1'b0, 1'b1, 3'b001, 4'b1010, 1'b0);
        chk_a("rst", 4'b0000, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 1'b1, 3'b001, 4'b1010, 1'b0);
        chk_a("load_a", 4'b1010, 1'b0, 1'b0, 1'b0);

        // Shifts and rotate.
        step_a(1'b1, 1'b0, 1'b1, 3'b010, 4'b0000, 1'b1);
        chk_a("shl", 4'b0101, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b011, 4'b1111, 1'b0);
        chk_a("shr", 4'b0010, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b101, 4'b1111, 1'b1);
        chk_a("rotr", 4'b0001, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b100, 4'b1111, 1'b0);
        chk_a("rotl", 4'b0010, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b000, 4'b1111, 1'b1);
        chk_a("hold_mode", 4'b0010, 1'b0, 1'b0, 1'b0);

        // Increment across the wrap; Ovf sticky; load clears it.
        step_a(1'b1, 1'b0, 1'b1, 3'b001, 4'b1110, 1'b0);
        chk_a("load_e", 4'b1110, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b110, 4'b0000, 1'b0);
        chk_a("inc1", 4'b1111, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b110, 4'b0000, 1'b0);
        chk_a("inc2", 4'b0000, 1'b0, 1'b1, 1'b1);
        step_a(1'b1, 1'b0, 1'b1, 3'b110, 4'b0000, 1'b0);
        chk_a("inc3", 4'b0001, 1'b0, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b001, 4'b0011, 1'b0);
        chk_a("load_3", 4'b0011, 1'b0, 1'b0, 1'b0);

        // Get Q=0 with Sout=1, then decrement below zero.
        step_a(1'b1, 1'b0, 1'b1, 3'b001, 4'b1000, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b010, 4'b0000, 1'b0);
        chk_a("shl_out1", 4'b0000, 1'b1, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 1'b1, 3'b111, 4'b0000, 1'b0);
        chk_a("dec_wrap", 4'b1111, 1'b1, 1'b1, 1'b0);

        // En=0 holds everything regardless of Mode/I/Sin.
        step_a(1'b1, 1'b0, 1'b0, 3'b110, 4'b0101, 1'b1);
        step_a(1'b1, 1'b0, 1'b0, 3'b110, 4'b1010, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 3'b110, 4'b0011, 1'b1);
        chk_a("en0_hold", 4'b1111, 1'b1, 1'b1, 1'b0);

        // Reach Q=0110 with Ovf=1; shifts leave Ovf alone.
        step_a(1'b1, 1'b0, 1'b1, 3'b011, 4'b0000, 1'b0);
        chk_a("shr_ovf", 4'b0111, 1'b1, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b111, 4'b0000, 1'b0);
        chk_a("dec_mid", 4'b0110, 1'b1, 1'b1, 1'b0);

        // Clr beats load.
        step_a(1'b1, 1'b1, 1'b1, 3'b001, 4'b1001, 1'b1);
        chk_a("clr", 4'b0000, 1'b0, 1'b0, 1'b1);

        // Nonzero state, then Rst and Clr together during an increment.
        step_a(1'b1, 1'b0, 1'b1, 3'b001, 4'b0101, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 3'b101, 4'b0000, 1'b0);
        chk_a("rotr_5", 4'b1010, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b1, 3'b110, 4'b1111, 1'b1);
        chk_a("rst_clr", 4'b0000, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0);

        // W=8, RST_VAL=A5.
        step_b(1'b0, 1'b0, 1'b1, 3'b001, 8'h3C, 1'b0);
        chk_b("b_rst", 8'hA5, 1'b0, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b1, 3'b100, 8'h00, 1'b0);
        chk_b("b_rotl", 8'h4B, 1'b1, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b1, 3'b001, 8'hFF, 1'b0);
        chk_b("b_load", 8'hFF, 1'b1, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
        chk_b("b_inc", 8'h00, 1'b1, 1'b1, 1'b1);
        step_b(1'b1, 1'b0, 1'b1, 3'b111, 8'h00, 1'b0);
        chk_b("b_dec", 8'hFF, 1'b1, 1'b1, 1'b0);
        step_b(1'b0, 1'b0, 1'b1, 3'b110, 8'h00, 1'b1);
        chk_b("b_rst2", 8'hA5, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
